// File: rtl/nonce_dispatcher_if.sv
// Signal bundle between the nonce dispatcher, the job receiver and the SHA-256d hasher.
// Handshake: an issue transfers on every rising hash_clk edge where hash_valid and
// hash_ready are both high. While hash_valid waits, hash_data is stable unless new_work
// replaces the job. result_valid/result_hit have no back-pressure and arrive in issue order.
interface nonce_dispatcher_if;
  logic         new_work;
  logic [255:0] midstate;
  logic [95:0]  work_data;
  logic [31:0]  nonce_min;
  logic [31:0]  nonce_max;
  logic         hash_valid;
  logic         hash_ready;
  logic [255:0] hash_midstate;
  logic [127:0] hash_data;
  logic         result_valid;
  logic         result_hit;
  logic [31:0]  golden_nonce;
  logic         new_golden_ticket;
  logic         busy;
  logic         exhausted;
  logic         proto_err;
  logic [1:0]   dbg_state;

  modport master (
    input  new_work, midstate, work_data, nonce_min, nonce_max,
    input  hash_ready, result_valid, result_hit,
    output hash_valid, hash_midstate, hash_data,
    output golden_nonce, new_golden_ticket, busy, exhausted, proto_err, dbg_state
  );

  modport slave (
    output new_work, midstate, work_data, nonce_min, nonce_max,
    output hash_ready, result_valid, result_hit,
    input  hash_valid, hash_midstate, hash_data,
    input  golden_nonce, new_golden_ticket, busy, exhausted, proto_err, dbg_state
  );
endinterface

// File: rtl/nonce_dispatcher.sv
// Walks the nonce range of the current job into the hasher and maps in-order results
// back to nonces, swallowing results that belong to a superseded job.
module nonce_dispatcher #(
  parameter int OUT_W = 8
) (
  input  logic              hash_clk,
  input  logic              reset_n,
  nonce_dispatcher_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [OUT_W-1:0] OUT_MAX = '1;
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [255:0]     r_midstate;
  logic [95:0]      r_work_data;
  logic [31:0]      r_issue_nonce;
  logic [31:0]      r_nonce_max;
  logic [31:0]      r_res_nonce;
  logic [31:0]      r_golden_nonce;
  logic [OUT_W-1:0] r_outstanding;
  logic [OUT_W-1:0] r_discard_cnt;
  logic [OUT_W-1:0] w_out_next;
  logic             r_hash_valid;
  logic             w_hash_valid_next;
  logic             r_ticket;
  logic             r_proto_err;
  logic             w_fire;
  logic             w_res_ok;
  logic             w_res_bad;
  logic             w_issue_last;
  logic             w_range_ok;

  assign w_fire       = r_hash_valid & bus.hash_ready;
  assign w_res_ok     = bus.result_valid & (r_outstanding != '0);
  assign w_res_bad    = bus.result_valid & (r_outstanding == '0);
  // Equality against the latched max ends the range without ever wrapping past FFFFFFFF.
  assign w_issue_last = (r_issue_nonce == r_nonce_max);
  assign w_range_ok   = (bus.nonce_min <= bus.nonce_max);

  always_comb begin
    w_out_next = r_outstanding;
    if (w_fire && !w_res_ok) begin
      w_out_next = r_outstanding + OUT_ONE;
    end else if (!w_fire && w_res_ok) begin
      w_out_next = r_outstanding - OUT_ONE;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_hash_valid_next = 1'b0;
    if (bus.new_work) begin
      w_state_next = w_range_ok ? ST_RUN : ST_DONE;
    end else if ((r_state == ST_RUN) && w_fire && w_issue_last) begin
      w_state_next = ST_DONE;
    end
    w_hash_valid_next = (w_state_next == ST_RUN) && (w_out_next != OUT_MAX);
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_midstate     <= '0;
      r_work_data    <= '0;
      r_issue_nonce  <= '0;
      r_nonce_max    <= '0;
      r_res_nonce    <= '0;
      r_golden_nonce <= '0;
      r_outstanding  <= '0;
      r_discard_cnt  <= '0;
      r_hash_valid   <= 1'b0;
      r_ticket       <= 1'b0;
      r_proto_err    <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      r_hash_valid  <= w_hash_valid_next;
      r_ticket      <= 1'b0;
      if (w_res_bad) begin
        r_proto_err <= 1'b1;
      end
      if (bus.new_work) begin
        // Everything still in flight after this edge belongs to the old job, including a
        // result consumed in this very cycle, which is therefore never attributed.
        r_midstate    <= bus.midstate;
        r_work_data   <= bus.work_data;
        r_issue_nonce <= bus.nonce_min;
        r_nonce_max   <= bus.nonce_max;
        r_res_nonce   <= bus.nonce_min;
        r_discard_cnt <= w_out_next;
      end else begin
        if (w_fire) begin
          r_issue_nonce <= r_issue_nonce + 32'd1;
        end
        if (w_res_ok) begin
          if (r_discard_cnt != '0) begin
            r_discard_cnt <= r_discard_cnt - OUT_ONE;
          end else begin
            if (bus.result_hit) begin
              r_golden_nonce <= r_res_nonce;
              r_ticket       <= 1'b1;
            end
            r_res_nonce <= r_res_nonce + 32'd1;
          end
        end
      end
    end
  end

  assign bus.hash_valid        = r_hash_valid;
  assign bus.hash_midstate     = r_midstate;
  assign bus.hash_data         = {r_work_data, r_issue_nonce};
  assign bus.golden_nonce      = r_golden_nonce;
  assign bus.new_golden_ticket = r_ticket;
  assign bus.proto_err         = r_proto_err;
  assign bus.dbg_state         = r_state;
  assign bus.busy              = (r_state != ST_IDLE) &&
                                 ((r_state == ST_RUN) || (r_outstanding != '0));
  assign bus.exhausted         = (r_state == ST_DONE) && (r_outstanding == '0);

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher: a job/result model tracks issued nonces by job and predicts
// tickets, status flags and issue order; a second instance with OUT_W=2 exercises the cap.
module tb_nonce_dispatcher;

  logic hash_clk = 1'b0;
  logic reset_n;
  always #5 hash_clk = ~hash_clk;

  nonce_dispatcher_if h ();
  nonce_dispatcher_if h2 ();

  nonce_dispatcher #(.OUT_W(8)) dut (.hash_clk(hash_clk), .reset_n(reset_n), .bus(h.master));
  nonce_dispatcher #(.OUT_W(2)) dut2 (.hash_clk(hash_clk), .reset_n(reset_n), .bus(h2.master));

  assign h2.new_work     = h.new_work;
  assign h2.midstate     = h.midstate;
  assign h2.work_data    = h.work_data;
  assign h2.nonce_min    = h.nonce_min;
  assign h2.nonce_max    = h.nonce_max;
  assign h2.hash_ready   = h.hash_ready;
  assign h2.result_valid = h.result_valid;
  assign h2.result_hit   = h.result_hit;

  typedef struct packed {
    logic [31:0] tag;
    logic [31:0] nonce;
  } flight_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  flight_t     inflight_q[$];
  int          ret_q[$];
  logic [31:0] obs_issue_q[$];
  logic [31:0] exp_issue_q[$];
  int          issue_cyc_q[$];
  logic [31:0] exp_ticket_q[$];
  logic [31:0] obs_ticket_q[$];
  logic [31:0] job_id = 0;
  logic [32:0] m_next = 0;
  logic [32:0] m_max = 0;
  bit          m_active = 0;
  bit          m_proto = 0;
  bit          auto_ret = 0;
  bit          manual_res = 0;
  int          ret_lo = 1;
  int          ret_hi = 1;
  int          hit_pct = 0;
  int          hit_idx = -1;
  int          res_idx = 0;

  // ---------------- reference model views ----------------
  function automatic bit m_all_issued();
    return m_next > m_max;
  endfunction

  function automatic bit exp_hv();
    return m_active && !m_all_issued() && (inflight_q.size() < 255);
  endfunction

  function automatic bit exp_busy();
    return m_active && (!m_all_issued() || inflight_q.size() != 0);
  endfunction

  function automatic bit exp_exh();
    return m_active && m_all_issued() && (inflight_q.size() == 0);
  endfunction

  // ---------------- driver: one clock cycle with hasher + model update ----------------
  task automatic tick();
    bit          fired;
    logic [31:0] fn;
    int          d;
    int          last;
    flight_t     f;
    if (!manual_res) begin
      h.result_valid = 1'b0;
      h.result_hit   = 1'b0;
      if (auto_ret && ret_q.size() > 0 && ret_q[0] <= cyc) begin
        d = ret_q.pop_front();
        h.result_valid = 1'b1;
        h.result_hit   = (res_idx == hit_idx) || (int'($urandom_range(1, 100)) <= hit_pct);
      end
    end
    fired = h.hash_valid && h.hash_ready;
    fn    = h.hash_data[31:0];
    if (reset_n) begin
      if (fired) begin
        inflight_q.push_back({job_id, m_next[31:0]});
        exp_issue_q.push_back(m_next[31:0]);
        obs_issue_q.push_back(fn);
        issue_cyc_q.push_back(cyc);
        m_next = m_next + 33'd1;
        last = (ret_q.size() > 0) ? ret_q[$] : 0;
        d = cyc + int'($urandom_range(ret_lo, ret_hi));
        ret_q.push_back((d < last) ? last : d);
      end
      if (h.new_work) begin
        job_id   = job_id + 32'd1;
        m_next   = {1'b0, h.nonce_min};
        m_max    = {1'b0, h.nonce_max};
        m_active = 1'b1;
      end
      if (h.result_valid) begin
        res_idx++;
        if (inflight_q.size() == 0) begin
          m_proto = 1'b1;
        end else begin
          f = inflight_q.pop_front();
          if (f.tag == job_id && h.result_hit) exp_ticket_q.push_back(f.nonce);
        end
      end
    end
    @(posedge hash_clk);
    #1;
    cyc++;
    h.new_work = 1'b0;
    if (reset_n && h.new_golden_ticket) obs_ticket_q.push_back(h.golden_nonce);
  endtask

  task automatic start_job(input logic [31:0] mn, input logic [31:0] mx);
    h.nonce_min = mn;
    h.nonce_max = mx;
    h.new_work  = 1'b1;
    tick();
  endtask

  task automatic clear_obs();
    obs_issue_q.delete();
    exp_issue_q.delete();
    issue_cyc_q.delete();
    obs_ticket_q.delete();
    exp_ticket_q.delete();
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    h.new_work     = 1'b0;
    h.result_valid = 1'b0;
    h.result_hit   = 1'b0;
    h.hash_ready   = 1'b0;
    manual_res     = 1'b0;
    auto_ret       = 1'b0;
    repeat (2) @(posedge hash_clk);
    #1;
    inflight_q.delete();
    ret_q.delete();
    clear_obs();
    m_active = 1'b0;
    m_proto  = 1'b0;
    m_next   = '0;
    m_max    = '0;
    res_idx  = 0;
    reset_n  = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n        = 1'b0;
    h.new_work     = 1'b0;
    h.midstate     = '0;
    h.work_data    = '0;
    h.nonce_min    = '0;
    h.nonce_max    = '0;
    h.hash_ready   = 1'b0;
    h.result_valid = 1'b0;
    h.result_hit   = 1'b0;
    #2;
    checks++; if ({h.hash_valid, h.new_golden_ticket, h.busy, h.exhausted, h.proto_err} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {h.hash_valid, h.new_golden_ticket, h.busy, h.exhausted, h.proto_err}); end
    checks++; if (h.hash_data !== 128'h0) begin errors++; $display("FAIL reset_hash_data got=%h exp=0", h.hash_data); end
    checks++; if (h.hash_midstate !== 256'h0) begin errors++; $display("FAIL reset_midstate got=%h exp=0", h.hash_midstate); end
    checks++; if (h.golden_nonce !== 32'h0) begin errors++; $display("FAIL reset_golden got=%h exp=0", h.golden_nonce); end
    checks++; if (h.dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", h.dbg_state); end
    do_reset();
  endtask

  task automatic test_basic_range();
    logic [255:0] ms;
    logic [95:0]  wd;
    for (int i = 0; i < 8; i++) ms[i*32 +: 32] = $urandom;
    for (int i = 0; i < 3; i++) wd[i*32 +: 32] = $urandom;
    clear_obs();
    h.hash_ready = 1'b1;
    auto_ret = 1'b1; ret_lo = 5; ret_hi = 5; hit_pct = 0;
    res_idx = 0; hit_idx = 2;
    h.midstate = ms;
    h.work_data = wd;
    start_job(32'h10, 32'h13);
    checks++; if (h.hash_midstate !== ms) begin errors++; $display("FAIL basic_midstate got=%h exp=%h", h.hash_midstate, ms); end
    checks++; if (h.hash_data !== {wd, 32'h10}) begin errors++; $display("FAIL basic_hash_data got=%h exp=%h", h.hash_data, {wd, 32'h10}); end
    h.midstate = ~ms;
    repeat (14) begin
      tick();
      checks++; if ({h.hash_valid, h.busy, h.exhausted} !== {exp_hv(), exp_busy(), exp_exh()}) begin errors++; $display("FAIL basic_status cyc=%0d got=%b exp=%b", cyc, {h.hash_valid, h.busy, h.exhausted}, {exp_hv(), exp_busy(), exp_exh()}); end
    end
    checks++; if (obs_issue_q.size() != 4) begin errors++; $display("FAIL basic_issue_count got=%0d exp=4", obs_issue_q.size()); end
    for (int i = 0; i < obs_issue_q.size() && i < 4; i++) begin
      checks++; if (obs_issue_q[i] !== 32'h10 + i || issue_cyc_q[i] - issue_cyc_q[0] != i) begin errors++; $display("FAIL basic_issue idx=%0d got=%h@+%0d exp=%h@+%0d", i, obs_issue_q[i], issue_cyc_q[i] - issue_cyc_q[0], 32'h10 + i, i); end
    end
    checks++; if (obs_ticket_q.size() != 1 || (obs_ticket_q.size() > 0 && obs_ticket_q[0] !== 32'h12)) begin errors++; $display("FAIL basic_ticket got_count=%0d exp_count=1 exp_nonce=12", obs_ticket_q.size()); end
    checks++; if (obs_ticket_q != exp_ticket_q) begin errors++; $display("FAIL basic_ticket_model got_count=%0d exp_count=%0d", obs_ticket_q.size(), exp_ticket_q.size()); end
    checks++; if (h.golden_nonce !== 32'h12) begin errors++; $display("FAIL basic_golden got=%h exp=12", h.golden_nonce); end
    checks++; if (h.exhausted !== 1'b1 || h.hash_midstate !== ms) begin errors++; $display("FAIL basic_end got_exh=%b exp_exh=1 midstate_held=%b", h.exhausted, h.hash_midstate === ms); end
  endtask

  task automatic test_top_of_range();
    clear_obs();
    h.hash_ready = 1'b1;
    auto_ret = 1'b1; ret_lo = 2; ret_hi = 4; hit_pct = 100; hit_idx = -1;
    start_job(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    repeat (12) begin
      tick();
      checks++; if ({h.hash_valid, h.busy, h.exhausted} !== {exp_hv(), exp_busy(), exp_exh()}) begin errors++; $display("FAIL top_status cyc=%0d got=%b exp=%b", cyc, {h.hash_valid, h.busy, h.exhausted}, {exp_hv(), exp_busy(), exp_exh()}); end
    end
    checks++; if (obs_issue_q.size() != 2 || obs_issue_q[0] !== 32'hFFFF_FFFE || obs_issue_q[obs_issue_q.size()-1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL top_issues got_count=%0d exp=2 (FFFFFFFE,FFFFFFFF)", obs_issue_q.size()); end
    checks++; if (h.dbg_state !== 2'd2 || h.exhausted !== 1'b1) begin errors++; $display("FAIL top_done got_state=%0d got_exh=%b exp=2/1", h.dbg_state, h.exhausted); end
    checks++; if (obs_ticket_q.size() != 2 || obs_ticket_q != exp_ticket_q) begin errors++; $display("FAIL top_tickets got_count=%0d exp_count=2", obs_ticket_q.size()); end
    checks++; if (h.golden_nonce !== 32'hFFFF_FFFF) begin errors++; $display("FAIL top_golden got=%h exp=FFFFFFFF", h.golden_nonce); end
  endtask

  task automatic test_empty_range();
    clear_obs();
    h.hash_ready = 1'b1;
    start_job(32'd5, 32'd4);
    checks++; if (h.hash_valid !== 1'b0 || h.exhausted !== 1'b1 || h.dbg_state !== 2'd2) begin errors++; $display("FAIL empty_latch got_hv=%b got_exh=%b got_state=%0d exp=0/1/2", h.hash_valid, h.exhausted, h.dbg_state); end
    repeat (4) tick();
    checks++; if (obs_issue_q.size() != 0 || h.exhausted !== 1'b1) begin errors++; $display("FAIL empty_hold got_issues=%0d got_exh=%b exp=0/1", obs_issue_q.size(), h.exhausted); end
  endtask

  task automatic test_job_switch();
    clear_obs();
    h.hash_ready = 1'b1;
    auto_ret = 1'b0; ret_lo = 2; ret_hi = 2; hit_pct = 100; hit_idx = -1;
    start_job(32'd0, 32'd99);
    repeat (6) tick();
    checks++; if (obs_issue_q.size() != 6) begin errors++; $display("FAIL switch_inflight got=%0d exp=6", obs_issue_q.size()); end
    start_job(32'd1000, 32'd1015);
    checks++; if (obs_issue_q.size() != 7 || obs_issue_q[obs_issue_q.size()-1] !== 32'd6) begin errors++; $display("FAIL switch_overlap got_count=%0d exp=7 last_exp=6", obs_issue_q.size()); end
    checks++; if (h.hash_valid !== 1'b1 || h.hash_data[31:0] !== 32'd1000) begin errors++; $display("FAIL switch_restart got_hv=%b got_nonce=%0d exp=1/1000", h.hash_valid, h.hash_data[31:0]); end
    auto_ret = 1'b1;
    repeat (40) begin
      tick();
      checks++; if ({h.hash_valid, h.busy, h.exhausted} !== {exp_hv(), exp_busy(), exp_exh()}) begin errors++; $display("FAIL switch_status cyc=%0d got=%b exp=%b", cyc, {h.hash_valid, h.busy, h.exhausted}, {exp_hv(), exp_busy(), exp_exh()}); end
    end
    checks++; if (obs_ticket_q.size() != 16) begin errors++; $display("FAIL switch_ticket_count got=%0d exp=16", obs_ticket_q.size()); end
    for (int i = 0; i < obs_ticket_q.size() && i < 16; i++) begin
      checks++; if (obs_ticket_q[i] !== 32'd1000 + i) begin errors++; $display("FAIL switch_ticket idx=%0d got=%0d exp=%0d", i, obs_ticket_q[i], 1000 + i); end
    end
    checks++; if (obs_ticket_q != exp_ticket_q) begin errors++; $display("FAIL switch_ticket_model got_count=%0d exp_count=%0d", obs_ticket_q.size(), exp_ticket_q.size()); end
  endtask

  task automatic test_random();
    logic [31:0] mn;
    logic [32:0] mx;
    int          n;
    clear_obs();
    auto_ret = 1'b1; ret_lo = 1; ret_hi = 6; hit_pct = 25; hit_idx = -1;
    for (int c = 0; c < 600; c++) begin
      h.hash_ready = ($urandom_range(0, 9) < 7);
      if (c == 0 || $urandom_range(0, 49) == 0) begin
        mn = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom_range(1, 5000);
        mx = {1'b0, mn} + 33'($urandom_range(0, 24));
        if (mx > 33'h0_FFFF_FFFF) mx = 33'h0_FFFF_FFFF;
        if ($urandom_range(0, 9) == 0) mx = {1'b0, mn - 32'd1};
        h.nonce_min = mn;
        h.nonce_max = mx[31:0];
        h.new_work  = 1'b1;
      end
      tick();
      checks++; if ({h.hash_valid, h.busy, h.exhausted} !== {exp_hv(), exp_busy(), exp_exh()}) begin errors++; $display("FAIL rand_status cyc=%0d got=%b exp=%b", cyc, {h.hash_valid, h.busy, h.exhausted}, {exp_hv(), exp_busy(), exp_exh()}); end
    end
    h.hash_ready = 1'b1;
    n = 0;
    while (n < 300 && !exp_exh()) begin
      tick();
      n++;
    end
    checks++; if (h.exhausted !== 1'b1) begin errors++; $display("FAIL rand_drain got_exh=%b exp=1 after %0d cycles", h.exhausted, n); end
    checks++; if (obs_issue_q.size() != exp_issue_q.size()) begin errors++; $display("FAIL rand_issue_count got=%0d exp=%0d", obs_issue_q.size(), exp_issue_q.size()); end
    for (int i = 0; i < obs_issue_q.size() && i < exp_issue_q.size(); i++) begin
      checks++; if (obs_issue_q[i] !== exp_issue_q[i]) begin errors++; $display("FAIL rand_issue idx=%0d got=%h exp=%h", i, obs_issue_q[i], exp_issue_q[i]); end
    end
    checks++; if (obs_ticket_q.size() != exp_ticket_q.size()) begin errors++; $display("FAIL rand_ticket_count got=%0d exp=%0d", obs_ticket_q.size(), exp_ticket_q.size()); end
    for (int i = 0; i < obs_ticket_q.size() && i < exp_ticket_q.size(); i++) begin
      checks++; if (obs_ticket_q[i] !== exp_ticket_q[i]) begin errors++; $display("FAIL rand_ticket idx=%0d got=%h exp=%h", i, obs_ticket_q[i], exp_ticket_q[i]); end
    end
  endtask

  task automatic test_proto_err_and_async_reset();
    do_reset();
    manual_res = 1'b1;
    h.result_valid = 1'b1;
    h.result_hit   = 1'b1;
    tick();
    h.result_valid = 1'b0;
    h.result_hit   = 1'b0;
    checks++; if (h.proto_err !== 1'b1 || h.new_golden_ticket !== 1'b0 || h.golden_nonce !== 32'h0) begin errors++; $display("FAIL proto_set got_err=%b got_tkt=%b got_golden=%h exp=1/0/0", h.proto_err, h.new_golden_ticket, h.golden_nonce); end
    tick();
    checks++; if (h.proto_err !== 1'b1 || h.new_golden_ticket !== 1'b0 || m_proto !== 1'b1) begin errors++; $display("FAIL proto_sticky got_err=%b got_tkt=%b exp=1/0", h.proto_err, h.new_golden_ticket); end
    manual_res = 1'b0;
    h.hash_ready = 1'b1;
    start_job(32'd0, 32'd99);
    repeat (5) tick();
    checks++; if (h.hash_valid !== 1'b1 || h.busy !== 1'b1) begin errors++; $display("FAIL midrun_active got_hv=%b got_busy=%b exp=1/1", h.hash_valid, h.busy); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if ({h.hash_valid, h.new_golden_ticket, h.busy, h.exhausted, h.proto_err} !== 5'b0) begin errors++; $display("FAIL async_reset_flags got=%b exp=00000", {h.hash_valid, h.new_golden_ticket, h.busy, h.exhausted, h.proto_err}); end
    checks++; if (h.hash_data !== 128'h0 || h.hash_midstate !== 256'h0 || h.dbg_state !== 2'd0) begin errors++; $display("FAIL async_reset_data got_data=%h got_state=%0d exp=0/0", h.hash_data, h.dbg_state); end
    do_reset();
  endtask

  task automatic test_outstanding_cap();
    int n2;
    do_reset();
    h.hash_ready = 1'b1;
    start_job(32'd0, 32'd99);
    n2 = 0;
    repeat (8) begin
      if (h2.hash_valid && h2.hash_ready) n2++;
      tick();
    end
    checks++; if (n2 != 3 || h2.hash_valid !== 1'b0) begin errors++; $display("FAIL cap_stall got_issues=%0d got_hv=%b exp=3/0", n2, h2.hash_valid); end
    manual_res = 1'b1;
    h.result_valid = 1'b1;
    h.result_hit   = 1'b0;
    checks++; if (h2.hash_valid !== 1'b0) begin errors++; $display("FAIL cap_pre_result got_hv=%b exp=0", h2.hash_valid); end
    tick();
    h.result_valid = 1'b0;
    checks++; if (h2.hash_valid !== 1'b1 || h2.hash_data[31:0] !== 32'd3) begin errors++; $display("FAIL cap_resume got_hv=%b got_nonce=%0d exp=1/3", h2.hash_valid, h2.hash_data[31:0]); end
    tick();
    checks++; if (h2.hash_valid !== 1'b0 || h2.hash_data[31:0] !== 32'd4) begin errors++; $display("FAIL cap_restall got_hv=%b got_nonce=%0d exp=0/4", h2.hash_valid, h2.hash_data[31:0]); end
    manual_res = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_range();
    test_top_of_range();
    test_empty_range();
    test_job_switch();
    test_random();
    test_proto_err_and_async_reset();
    test_outstanding_cap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
